// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: alignment check, data-cache request/ready handshake,
// byte-lane steering for stores and extraction/extension of load data.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_address,
  input  logic [WORD_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic                  resp_fault,
  output logic [WORD_W-1:0]     resp_rdata,
  output logic [ADDR_W-1:0]     dcache_address,
  output logic                  dcache_dataRequest,
  output logic                  dcache_rw,
  output logic [WORD_W-1:0]     dcache_writeData,
  output logic [WORD_W/8-1:0]   dcache_byte_en,
  input  logic [WORD_W-1:0]     dcache_readData,
  input  logic                  dcache_data_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, FAULT} state_t;

  state_t                state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic                  unsigned_q, unsigned_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  dreq_q, dreq_d;
  logic                  rw_q, rw_d;
  logic [ADDR_W-1:0]     daddr_q, daddr_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic [WORD_W/8-1:0]   be_q, be_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_fault_q, resp_fault_d;
  logic [WORD_W-1:0]     resp_rdata_q, resp_rdata_d;

  logic                  accept;
  logic                  misaligned;
  logic [WORD_W-1:0]     shifted;
  logic [WORD_W-1:0]     load_ext;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    misaligned = 1'b0;
    unique case (req_size)
      2'd0: misaligned = 1'b0;
      2'd1: misaligned = req_address[0];
      2'd2: misaligned = (req_address[1:0] != 2'b00);
      2'd3: misaligned = 1'b1;
    endcase
  end

  // Load data uses the latched offset/size, since req_* may already carry the next op.
  always_comb begin
    shifted  = dcache_readData >> {off_q, 3'b000};
    load_ext = shifted;
    unique case (size_q)
      2'd0:    load_ext = {{(WORD_W-8){shifted[7] & ~unsigned_q}}, shifted[7:0]};
      2'd1:    load_ext = {{(WORD_W-16){shifted[15] & ~unsigned_q}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    unsigned_d   = unsigned_q;
    size_d       = size_q;
    off_d        = off_q;
    dreq_d       = dreq_q;
    rw_d         = rw_q;
    daddr_d      = daddr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          is_store_d = req_is_store;
          unsigned_d = req_unsigned;
          size_d     = req_size;
          off_d      = req_address[1:0];
          if (misaligned) begin
            state_d      = FAULT;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            state_d = ACCESS;
            dreq_d  = 1'b1;
            rw_d    = req_is_store;
            daddr_d = {req_address[ADDR_W-1:2], 2'b00};
            unique case (req_size)
              2'd0: begin
                be_d    = 4'b0001 << req_address[1:0];
                wdata_d = {4{req_wdata[7:0]}};
              end
              2'd1: begin
                be_d    = req_address[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{req_wdata[15:0]}};
              end
              default: begin
                be_d    = 4'b1111;
                wdata_d = req_wdata;
              end
            endcase
            if (!req_is_store) wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (dcache_data_ready) begin
          state_d      = IDLE;
          dreq_d       = 1'b0;
          rw_d         = 1'b0;
          daddr_d      = '0;
          wdata_d      = '0;
          be_d         = '0;
          resp_valid_d = 1'b1;
          resp_rdata_d = is_store_q ? '0 : load_ext;
        end
      end
      FAULT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      dreq_q       <= 1'b0;
      rw_q         <= 1'b0;
      daddr_q      <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      unsigned_q   <= unsigned_d;
      size_q       <= size_d;
      off_q        <= off_d;
      dreq_q       <= dreq_d;
      rw_q         <= rw_d;
      daddr_q      <= daddr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign dcache_dataRequest = dreq_q;
  assign dcache_rw          = rw_q;
  assign dcache_address     = daddr_q;
  assign dcache_writeData   = wdata_q;
  assign dcache_byte_en     = be_q;
  assign resp_valid         = resp_valid_q;
  assign resp_fault         = resp_fault_q;
  assign resp_rdata         = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized ops
// checked against an arithmetic model of the lane/extension rules.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_address = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] dcache_address;
  logic        dcache_dataRequest;
  logic        dcache_rw;
  logic [31:0] dcache_writeData;
  logic [3:0]  dcache_byte_en;
  logic [31:0] dcache_readData = '0;
  logic        dcache_data_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_W(32), .WORD_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_fault(resp_fault),
    .resp_rdata(resp_rdata), .dcache_address(dcache_address),
    .dcache_dataRequest(dcache_dataRequest), .dcache_rw(dcache_rw),
    .dcache_writeData(dcache_writeData), .dcache_byte_en(dcache_byte_en),
    .dcache_readData(dcache_readData), .dcache_data_ready(dcache_data_ready)
  );

  typedef struct {
    bit          accepted;
    int          accept_wait;
    bit          got_resp;
    int          latency;
    int          req_cycles;
    int          first_req;
    bit          unstable;
    bit          leak;
    logic        fault;
    logic [31:0] rdata;
    logic        ready_at_resp;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        rw;
    logic [31:0] wd;
  } obs_t;

  typedef struct {
    bit          fault;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
  } exp_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: sizes are 1/2/4 bytes; lanes and extension from plain arithmetic.
  function automatic exp_t model(input bit st, input int size, input bit uns,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd);
    exp_t e;
    int nb, off;
    logic [31:0] mask, v;
    off = int'(a % 4);
    e.addr = a - 32'(off);
    e.be = '0; e.wd = '0; e.rdata = '0;
    if (size == 3) begin
      e.fault = 1'b1;
      return e;
    end
    nb = 1 << size;
    e.fault = (a % 32'(nb)) != 0;
    if (e.fault) return e;
    e.be = 4'(((1 << nb) - 1) << off);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    if (st) begin
      v = wd & mask;
      for (int k = 0; k < 4 / nb; k++) e.wd = e.wd | (v << (8 * nb * k));
    end else begin
      e.rdata = (rd >> (8 * off)) & mask;
      if (!uns && nb < 4 && e.rdata[8 * nb - 1]) e.rdata = e.rdata | ~mask;
    end
    return e;
  endfunction

  // Presents one op, plays a cache with `waits` wait states; returns observations only.
  task automatic run_op(input bit st, input logic [1:0] size, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int waits, output obs_t o);
    o = '{default: 0};
    req_valid = 1'b1; req_is_store = st; req_size = size;
    req_unsigned = uns; req_address = a; req_wdata = wd;
    while (!req_ready && o.accept_wait < 20) begin
      tick();
      o.accept_wait++;
    end
    o.accepted = req_ready;
    tick();
    req_valid = 1'b0;
    req_address = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_is_store = 1'($urandom); req_unsigned = 1'($urandom);
    for (int c = 1; c <= 40 && o.accepted; c++) begin
      dcache_data_ready = 1'b0;
      if (!resp_valid && resp_rdata !== 32'd0) o.leak = 1'b1;
      if (resp_valid) begin
        o.got_resp = 1'b1;
        o.latency = c;
        o.fault = resp_fault;
        o.rdata = resp_rdata;
        o.ready_at_resp = req_ready;
        break;
      end
      if (dcache_dataRequest) begin
        o.req_cycles++;
        if (o.req_cycles == 1) begin
          o.first_req = c;
          o.addr = dcache_address; o.be = dcache_byte_en;
          o.rw = dcache_rw; o.wd = dcache_writeData;
        end else if (o.addr !== dcache_address || o.be !== dcache_byte_en ||
                     o.rw !== dcache_rw || o.wd !== dcache_writeData) begin
          o.unstable = 1'b1;
        end
        if (o.req_cycles == waits + 1) begin
          dcache_data_ready = 1'b1;
          dcache_readData = rd;
        end else begin
          dcache_readData = $urandom;
        end
      end
      tick();
    end
    dcache_data_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_checks++;
    if ({resp_valid, resp_fault, resp_rdata, dcache_dataRequest, dcache_rw,
         dcache_address, dcache_writeData, dcache_byte_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b fault=%b rdata=%h req=%b rw=%b addr=%h wd=%h be=%b, want all 0",
               resp_valid, resp_fault, resp_rdata, dcache_dataRequest, dcache_rw,
               dcache_address, dcache_writeData, dcache_byte_en);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    dcache_data_ready = 1'b1;
    tick();
    dcache_data_ready = 1'b0;
    tick();
    n_checks++;
    if (resp_valid !== 1'b0 || dcache_dataRequest !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ready_ignored: got resp_valid=%b req=%b want 0 0", resp_valid, dcache_dataRequest);
    end
  endtask

  task automatic test_word_load();
    obs_t o;
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 3, o);
    n_checks++;
    if (o.addr !== 32'h104 || o.be !== 4'b1111 || o.rw !== 1'b0 || o.wd !== 32'h0) begin
      n_fail++;
      $display("FAIL word_load_cache: got addr=%h be=%b rw=%b wd=%h want 104 1111 0 0", o.addr, o.be, o.rw, o.wd);
    end
    n_checks++;
    if (o.req_cycles !== 4 || o.unstable !== 1'b0) begin
      n_fail++; $display("FAIL word_load_hold: got cycles=%0d unstable=%b want 4 0", o.req_cycles, o.unstable);
    end
    n_checks++;
    if (o.got_resp !== 1'b1 || o.latency !== 5 || o.rdata !== 32'hDEAD_BEEF || o.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL word_load_resp: got resp=%b lat=%0d rdata=%h fault=%b want 1 5 deadbeef 0",
               o.got_resp, o.latency, o.rdata, o.fault);
    end
    tick();
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL resp_single_cycle: got valid=%b rdata=%h want 0 0", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_byte_load();
    obs_t o;
    run_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_1234, 0, o);
    n_checks++;
    if (o.be !== 4'b1000 || o.addr !== 32'h100 || o.rdata !== 32'hFFFF_FF80) begin
      n_fail++;
      $display("FAIL byte_load_signed: got be=%b addr=%h rdata=%h want 1000 100 ffffff80", o.be, o.addr, o.rdata);
    end
    run_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_1234, 1, o);
    n_checks++;
    if (o.be !== 4'b1000 || o.rdata !== 32'h0000_0080 || o.latency !== 3) begin
      n_fail++;
      $display("FAIL byte_load_unsigned: got be=%b rdata=%h lat=%0d want 1000 00000080 3", o.be, o.rdata, o.latency);
    end
  endtask

  task automatic test_half_store();
    obs_t o;
    run_op(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD, 32'h1234_5678, 0, o);
    n_checks++;
    if (o.be !== 4'b1100 || o.wd !== 32'hABCD_ABCD || o.rw !== 1'b1 || o.addr !== 32'h200) begin
      n_fail++;
      $display("FAIL half_store_cache: got be=%b wd=%h rw=%b addr=%h want 1100 abcdabcd 1 200", o.be, o.wd, o.rw, o.addr);
    end
    n_checks++;
    if (o.got_resp !== 1'b1 || o.rdata !== 32'h0 || o.fault !== 1'b0 || o.latency !== 2) begin
      n_fail++;
      $display("FAIL half_store_resp: got resp=%b rdata=%h fault=%b lat=%0d want 1 0 0 2", o.got_resp, o.rdata, o.fault, o.latency);
    end
  endtask

  task automatic test_fault();
    obs_t o;
    run_op(1'b0, 2'd2, 1'b0, 32'h301, 32'h0, 32'h0, 0, o);
    n_checks++;
    if (o.got_resp !== 1'b1 || o.latency !== 1 || o.fault !== 1'b1 || o.rdata !== 32'h0 || o.req_cycles !== 0) begin
      n_fail++;
      $display("FAIL misaligned_word: got resp=%b lat=%0d fault=%b rdata=%h reqs=%0d want 1 1 1 0 0",
               o.got_resp, o.latency, o.fault, o.rdata, o.req_cycles);
    end
    run_op(1'b1, 2'd3, 1'b0, 32'h300, 32'hFFFF_FFFF, 32'h0, 0, o);
    n_checks++;
    if (o.got_resp !== 1'b1 || o.latency !== 1 || o.fault !== 1'b1 || o.rdata !== 32'h0 || o.req_cycles !== 0) begin
      n_fail++;
      $display("FAIL reserved_size: got resp=%b lat=%0d fault=%b rdata=%h reqs=%0d want 1 1 1 0 0",
               o.got_resp, o.latency, o.fault, o.rdata, o.req_cycles);
    end
    tick();
    n_checks++;
    if (dcache_dataRequest !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL fault_return_idle: got req=%b ready=%b want 0 1", dcache_dataRequest, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    run_op(1'b1, 2'd2, 1'b0, 32'h400, 32'h1122_3344, 32'h0, 0, o1);
    n_checks++;
    if (o1.ready_at_resp !== 1'b1 || dcache_dataRequest !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got ready=%b req=%b in resp cycle want 1 0", o1.ready_at_resp, dcache_dataRequest);
    end
    run_op(1'b0, 2'd1, 1'b0, 32'h406, 32'h0, 32'h8001_7FFF, 0, o2);
    n_checks++;
    if (o2.accept_wait !== 0 || o2.first_req !== 1 || o2.latency !== 2) begin
      n_fail++;
      $display("FAIL b2b_accept: got wait=%0d first_req=%0d lat=%0d want 0 1 2", o2.accept_wait, o2.first_req, o2.latency);
    end
    n_checks++;
    if (o1.wd !== 32'h1122_3344 || o1.rdata !== 32'h0 || o2.be !== 4'b1100 || o2.rdata !== 32'hFFFF_8001) begin
      n_fail++;
      $display("FAIL b2b_data: got wd1=%h r1=%h be2=%b r2=%h want 11223344 0 1100 ffff8001",
               o1.wd, o1.rdata, o2.be, o2.rdata);
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    bit seen = 1'b0;
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_address = 32'h500;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (dcache_dataRequest !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_setup: got req=%b want 1", dcache_dataRequest);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dcache_data_ready = 1'b1; dcache_readData = 32'hCAFE_F00D;
    n_checks++;
    if (dcache_dataRequest !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_drop: got req=%b valid=%b ready=%b want 0 0 1", dcache_dataRequest, resp_valid, req_ready);
    end
    tick();
    dcache_data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_late_ready: got resp_valid seen=%b want 0", seen);
    end
    run_op(1'b0, 2'd0, 1'b1, 32'h502, 32'h0, 32'h00AB_0000, 2, o);
    n_checks++;
    if (o.got_resp !== 1'b1 || o.rdata !== 32'h0000_00AB || o.be !== 4'b0100 || o.latency !== 4) begin
      n_fail++;
      $display("FAIL mid_reset_next_load: got resp=%b rdata=%h be=%b lat=%0d want 1 000000ab 0100 4",
               o.got_resp, o.rdata, o.be, o.latency);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    bit st, uns;
    logic [1:0] sz;
    logic [31:0] a, wd, rd;
    int w;
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
      a = $urandom; wd = $urandom; rd = $urandom; w = $urandom_range(0, 3);
      e = model(st, int'(sz), uns, a, wd, rd);
      run_op(st, sz, uns, a, wd, rd, w, o);
      n_checks++;
      if (o.got_resp !== 1'b1 || o.fault !== e.fault || o.rdata !== e.rdata || o.leak !== 1'b0 ||
          o.latency !== (e.fault ? 1 : w + 2) || o.unstable !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_resp[%0d] st=%b sz=%0d a=%h: got resp=%b fault=%b rdata=%h lat=%0d leak=%b unst=%b want fault=%b rdata=%h lat=%0d",
                 i, st, sz, a, o.got_resp, o.fault, o.rdata, o.latency, o.leak, o.unstable,
                 e.fault, e.rdata, e.fault ? 1 : w + 2);
      end
      if (!e.fault) begin
        n_checks++;
        if (o.addr !== e.addr || o.be !== e.be || o.wd !== e.wd || o.rw !== st || o.req_cycles !== w + 1) begin
          n_fail++;
          $display("FAIL rand_cache[%0d] st=%b sz=%0d a=%h: got addr=%h be=%b wd=%h rw=%b reqs=%0d want %h %b %h %b %0d",
                   i, st, sz, a, o.addr, o.be, o.wd, o.rw, o.req_cycles, e.addr, e.be, e.wd, st, w + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_fault();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Pipeline MEM-stage block between the execute stage and the memory subsystem's data-cache port.
- Accepts one load/store per transaction from the pipeline, checks alignment, and generates the word-aligned address, byte enables and lane-replicated write data.
- Runs the request/ready handshake with the data cache.
- Returns extracted, sign- or zero-extended load data, or a fault indication, to writeback.

Parameters:
- ADDR_W, 32, address width (matches DRAM_ADDRESS_SIZE)
- WORD_W, 32, data word width (matches DRAM_WORD_SIZE); fixed at 32 in this revision

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline presents a memory op
- req_ready  out  1  LSU accepts req_* this cycle
- req_is_store  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- req_unsigned  in  1  load zero-extends when 1
- req_address  in  ADDR_W  byte address
- req_wdata  in  WORD_W  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_fault  out  1  misaligned/reserved-size fault, valid with resp_valid
- resp_rdata  out  WORD_W  extended load data (0 for stores/faults)
- dcache_address  out  ADDR_W  word-aligned address to cache
- dcache_dataRequest  out  1  cache request valid
- dcache_rw  out  1  1=write, 0=read
- dcache_writeData  out  WORD_W  lane-replicated store data
- dcache_byte_en  out  WORD_W/8  byte enables
- dcache_readData  in  WORD_W  cache read word
- dcache_data_ready  in  1  cache completion, one-cycle pulse

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0 except req_ready; req_ready=1 from the first cycle after reset deasserts.
- States: IDLE, ACCESS, FAULT.
- req_ready=1 only in IDLE; acceptance = req_valid & req_ready. All req_* fields are latched on acceptance.
- Alignment check at acceptance: fault if size=1 & addr[0]; size=2 & addr[1:0]!=0; size=3.
- IDLE, accept, fault: go to FAULT. Next cycle: resp_valid=1, resp_fault=1, resp_rdata=0. No cache access. Then IDLE.
- IDLE, accept, aligned: go to ACCESS. Cache outputs are registered and valid in the next cycle:
  - dcache_dataRequest=1
  - dcache_address={addr[ADDR_W-1:2],2'b00}
  - dcache_rw=req_is_store
  - byte_en: byte=1<<addr[1:0]; half=addr[1]?1100:0011; word=1111
  - writeData: byte={4{wdata[7:0]}}; half={2{wdata[15:0]}}; word=wdata
  - Loads drive the same byte_en; writeData=0 for loads.
- ACCESS: all dcache_* outputs held stable until dcache_data_ready is sampled high.
  - On that cycle the read word is captured and the state returns to IDLE.
  - Next cycle: dcache_dataRequest=0 and resp_valid=1, resp_fault=0.
  - Minimum latency is accept -> resp_valid = 2 cycles with a 0-wait cache.
- Load extraction: sh = readData >> (8*addr[1:0]); byte: low 8 bits; half: low 16 bits. Sign-extend unless req_unsigned; word passes through. For stores, resp_rdata=0.
- Back-to-back: req_ready=1 in the resp_valid cycle, so a new op can be accepted then. dcache_dataRequest is therefore low for at least 1 cycle between transactions.
- resp_valid, resp_fault and resp_rdata are single-cycle; resp_rdata=0 whenever resp_valid=0.
- dcache_data_ready while not in ACCESS is ignored.
- Reset mid-ACCESS: next cycle dcache_dataRequest=0, no resp_valid, state IDLE; a late ready is ignored per the rule above.
- No internal queueing: at most one outstanding transaction.

Test Plan:
- Word load, addr 0x0000_0104, cache returns 0xDEAD_BEEF after 3 wait cycles -> dcache_address 0x104, byte_en 1111, rw 0, request held 4 cycles; resp_valid 1 cycle later with rdata 0xDEAD_BEEF.
- Signed byte load addr 0x103, readData 0x80FF_1234 -> byte_en 1000, rdata 0xFFFF_FF80; same with req_unsigned=1 -> 0x0000_0080.
- Half store addr 0x202, wdata 0x0000_ABCD -> byte_en 1100, writeData 0xABCD_ABCD, rw 1; resp_valid with rdata 0, fault 0.
- Misaligned word load addr 0x301, then size=3 at addr 0x300 -> each gives resp_valid+resp_fault 1 cycle after accept; dcache_dataRequest never asserted.
- Back-to-back store then load with 0-wait cache -> second accepted in first's resp_valid cycle; one idle request cycle between them; both responses correct.
- Reset asserted during ACCESS, ready pulsed the following cycle -> request drops, no resp_valid, req_ready=1 after reset; next load completes normally.
